// File: rtl/add_sel_reg.sv
// ============================================================================
// add_sel_reg
// ----------------------------------------------------------------------------
// Channel-selecting adder with a single registered result and a ready/valid
// handshake on both sides.
//
// Each accepted request picks one of NCH operand channels with 'sel'. It then
// either loads sum = x[sel] + y[sel], or accumulates sum = sum + x[sel]. The
// result sits in 'sum' with out_valid high until the consumer takes it. A new
// request can be accepted in the same cycle the old result is consumed, so the
// block sustains one result per cycle.
//
// Parameters
//   WIDTH : operand/result width in bits (1..32)
//   NCH   : number of input channels (1..16)
//   SAT   : 0 = wrap modulo 2^WIDTH on overflow, 1 = saturate to all-ones
//   INIT  : reset/clear value of sum (truncated to WIDTH bits)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a request is present
//   in_ready   : the block can take a request this cycle
//   x, y       : packed channel operands, channel k at [k*WIDTH +: WIDTH]
//   sel        : selected channel index
//   acc        : 1 = accumulate into sum, 0 = load x+y
//   clr        : synchronous clear of sum/ovf/err/out_valid (drops a request)
//   out_valid  : sum holds a result that has not been consumed
//   out_ready  : the consumer takes the result this cycle
//   sum        : registered result
//   ovf        : sticky overflow flag
//   err        : sticky illegal-channel flag
// ============================================================================
module add_sel_reg #(
    parameter int          WIDTH = 8,
    parameter int          NCH   = 4,
    parameter int          SAT   = 0,
    parameter logic [31:0] INIT  = 32'd0,
    localparam int         SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   x,
    input  logic [NCH*WIDTH-1:0]   y,
    input  logic [SELW-1:0]        sel,
    input  logic                   acc,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic                   ovf,
    output logic                   err
);

    // Reset/clear value of sum, cut down to the datapath width.
    localparam logic [WIDTH-1:0] INIT_VAL = INIT[WIDTH-1:0];

    logic              accept;
    logic [31:0]       sel_wide;
    logic              sel_ok;
    logic [WIDTH-1:0]  op_x;
    logic [WIDTH-1:0]  op_y;
    logic [WIDTH:0]    raw;
    logic              carry;
    logic [WIDTH-1:0]  result;

    // The single result register can take a new value whenever it is empty
    // or is being emptied this very cycle. clr does not affect readiness; a
    // request that meets clr is simply dropped.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel_wide = 32'(sel);

    // Channel mux. An index that matches no channel leaves both operands at
    // zero and sel_ok low, so a load yields 0 and an accumulate adds nothing.
    // With a single channel the index is ignored and channel 0 always wins.
    always_comb begin
        sel_ok = 1'b0;
        op_x   = '0;
        op_y   = '0;
        for (int k = 0; k < NCH; k++) begin
            if ((NCH == 1) || (sel_wide == 32'(k))) begin
                sel_ok = 1'b1;
                op_x   = x[k*WIDTH +: WIDTH];
                op_y   = y[k*WIDTH +: WIDTH];
            end
        end
    end

    // One extra bit of headroom catches the carry. Accumulate reads the
    // current register even if that result was never consumed.
    always_comb begin
        raw = '0;
        if (acc) begin
            raw = {1'b0, sum} + {1'b0, op_x};
        end else begin
            raw = {1'b0, op_x} + {1'b0, op_y};
        end
        carry  = raw[WIDTH];
        result = raw[WIDTH-1:0];
        if (carry && (SAT != 0)) begin
            result = '1;
        end
    end

    // Result register and sticky flags. Clear outranks an accept in the same
    // cycle. out_valid is refreshed by an accept and only drops once the
    // consumer takes the result without a new accept behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= INIT_VAL;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (clr) begin
            sum       <= INIT_VAL;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            sum       <= result;
            out_valid <= 1'b1;
            if (carry) begin
                ovf <= 1'b1;
            end
            if (!sel_ok) begin
                err <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_sel_reg.sv
// ============================================================================
// tb_add_sel_reg
// ----------------------------------------------------------------------------
// Drives several differently parameterised copies of add_sel_reg from one
// shared stimulus bus and compares every copy against an arithmetic model of
// the adder behaviour after each clock edge and around asynchronous resets.
// ============================================================================
module tb_add_sel_reg;

    localparam int NI = 7;
    localparam int          CW [NI] = '{8, 8, 8, 1, 32, 32, 8};
    localparam int          CN [NI] = '{4, 4, 3, 1, 16, 3, 16};
    localparam int          CS [NI] = '{0, 1, 0, 0, 1, 0, 0};
    localparam logic [31:0] CI [NI] = '{32'h0, 32'h0, 32'h5A, 32'h1,
                                        32'hDEADBEEF, 32'h0, 32'h3C};

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         acc;
    logic         clr;
    logic         out_ready;
    logic [511:0] xBus;
    logic [511:0] yBus;
    logic [3:0]   selBus;

    logic [31:0]  sumW [NI];
    logic         ovfW [NI];
    logic         errW [NI];
    logic         ovW  [NI];
    logic         irW  [NI];

    // Reference state, one entry per instance.
    longint unsigned mSum [NI];
    bit              mOvf [NI];
    bit              mErr [NI];
    bit              mVal [NI];

    int nVec;
    int nChecks;
    int nMis;

    // Device instances, one per parameter set.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W  = CW[g];
        localparam int N  = CN[g];
        localparam int SW = (N > 1) ? $clog2(N) : 1;
        logic [W-1:0] s;

        add_sel_reg #(
            .WIDTH(W),
            .NCH  (N),
            .SAT  (CS[g]),
            .INIT (CI[g])
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (irW[g]),
            .x        (xBus[N*W-1:0]),
            .y        (yBus[N*W-1:0]),
            .sel      (selBus[SW-1:0]),
            .acc      (acc),
            .clr      (clr),
            .out_valid(ovW[g]),
            .out_ready(out_ready),
            .sum      (s),
            .ovf      (ovfW[g]),
            .err      (errW[g])
        );

        assign sumW[g] = 32'(s);
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned maskOf(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic cmp(input string tag, input int i,
                       input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nMis++;
            $error("[TB] FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            mSum[i] = longint'(CI[i]) & maskOf(CW[i]);
            mOvf[i] = 1'b0;
            mErr[i] = 1'b0;
            mVal[i] = 1'b0;
        end
    endtask

    // What each instance should hold after a rising edge with the current inputs.
    task automatic modelClock();
        for (int i = 0; i < NI; i++) begin
            longint unsigned m;
            longint unsigned ox;
            longint unsigned oy;
            longint unsigned tot;
            int sw;
            int ch;
            bit legal;
            m  = maskOf(CW[i]);
            sw = (CN[i] > 1) ? $clog2(CN[i]) : 1;
            ch = (CN[i] == 1) ? 0 : (int'(selBus) & ((1 << sw) - 1));
            legal = (ch < CN[i]);
            if (clr) begin
                mSum[i] = longint'(CI[i]) & m;
                mOvf[i] = 1'b0;
                mErr[i] = 1'b0;
                mVal[i] = 1'b0;
            end else if (in_valid && (!mVal[i] || out_ready)) begin
                ox = legal ? (longint'(xBus[ch*CW[i] +: 32]) & m) : 64'd0;
                oy = legal ? (longint'(yBus[ch*CW[i] +: 32]) & m) : 64'd0;
                tot = acc ? (mSum[i] + ox) : (ox + oy);
                if (tot > m) begin
                    mOvf[i] = 1'b1;
                    mSum[i] = (CS[i] != 0) ? m : (tot & m);
                end else begin
                    mSum[i] = tot;
                end
                if (!legal) mErr[i] = 1'b1;
                mVal[i] = 1'b1;
            end else if (out_ready) begin
                mVal[i] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < NI; i++) begin
            cmp({tag, ".sum"},       i, 64'(sumW[i]), 64'(mSum[i]));
            cmp({tag, ".ovf"},       i, 64'(ovfW[i]), 64'(mOvf[i]));
            cmp({tag, ".err"},       i, 64'(errW[i]), 64'(mErr[i]));
            cmp({tag, ".out_valid"}, i, 64'(ovW[i]),  64'(mVal[i]));
            cmp({tag, ".in_ready"},  i, 64'(irW[i]),  64'(!mVal[i] || out_ready));
        end
    endtask

    // Present one request, check readiness before the edge and all state after.
    task automatic applyStimulus(input string tag, input logic iv, input logic a,
                                 input logic c, input logic orv, input logic [3:0] sl);
        in_valid  = iv;
        acc       = a;
        clr       = c;
        out_ready = orv;
        selBus    = sl;
        #1;
        for (int i = 0; i < NI; i++) begin
            cmp({tag, ".in_ready_pre"}, i, 64'(irW[i]), 64'(!mVal[i] || out_ready));
        end
        @(posedge clk);
        modelClock();
        #1;
        checkOutput(tag);
        nVec++;
    endtask

    task automatic randomData();
        for (int k = 0; k < 16; k++) begin
            xBus[k*32 +: 32] = $urandom;
            yBus[k*32 +: 32] = $urandom;
        end
    endtask

    // Assert reset between clock edges and check the outputs react at once.
    task automatic midCycleReset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        nVec = 0; nChecks = 0; nMis = 0;
        rst_n = 1'b0; in_valid = 1'b0; acc = 1'b0; clr = 1'b0;
        out_ready = 1'b0; selBus = 4'd0; xBus = '0; yBus = '0;
        modelReset();

        // Reset state, including in_ready held high during reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load channel 2: 0x12 + 0x34.
        xBus[2*8 +: 8] = 8'h12;
        yBus[2*8 +: 8] = 8'h34;
        applyStimulus("load_ch2", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        cmp("load_ch2_sum_const", 0, 64'(sumW[0]), 64'h46);
        cmp("load_ch2_val_const", 0, 64'(ovW[0]),  64'h1);
        cmp("load_ch2_ovf_const", 0, 64'(ovfW[0]), 64'h0);

        // Overflow on load, then sticky overflow on accumulate; wrap vs saturate.
        xBus = '0; yBus = '0;
        xBus[7:0] = 8'hF0;
        yBus[7:0] = 8'h20;
        applyStimulus("ovf_load", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        cmp("ovf_load_wrap", 0, 64'(sumW[0]), 64'h10);
        cmp("ovf_load_sat",  1, 64'(sumW[1]), 64'hFF);
        cmp("ovf_load_flag", 0, 64'(ovfW[0]), 64'h1);
        xBus[7:0] = 8'h01;
        applyStimulus("ovf_acc", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        cmp("ovf_acc_wrap",   0, 64'(sumW[0]), 64'h11);
        cmp("ovf_acc_sat",    1, 64'(sumW[1]), 64'hFF);
        cmp("ovf_acc_sticky", 0, 64'(ovfW[0]), 64'h1);

        // Back-pressure: result held, requests ignored for five cycles.
        for (int n = 0; n < 5; n++) begin
            randomData();
            applyStimulus("stall", 1'b1, n[0], 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            cmp("stall_hold_sum", 0, 64'(sumW[0]), 64'h11);
            cmp("stall_ready",    0, 64'(irW[0]),  64'h0);
        end
        // Back-to-back results with the consumer always ready.
        for (int n = 0; n < 4; n++) begin
            randomData();
            applyStimulus("b2b", 1'b1, n[0], 1'b0, 1'b1, 4'($urandom_range(0, 15)));
            cmp("b2b_valid", 0, 64'(ovW[0]), 64'h1);
        end

        // Illegal channel on the three-channel instance, then clear beats accept.
        randomData();
        applyStimulus("bad_sel", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        cmp("bad_sel_sum", 2, 64'(sumW[2]), 64'h0);
        cmp("bad_sel_err", 2, 64'(errW[2]), 64'h1);
        cmp("bad_sel_val", 2, 64'(ovW[2]),  64'h1);
        applyStimulus("clr_drop", 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
        cmp("clr_sum", 2, 64'(sumW[2]), 64'h5A);
        cmp("clr_err", 2, 64'(errW[2]), 64'h0);
        cmp("clr_val", 2, 64'(ovW[2]),  64'h0);

        // Asynchronous reset while a result is pending.
        randomData();
        applyStimulus("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        in_valid = 1'b0;
        midCycleReset("async_rst");
        cmp("async_rst_sum", 2, 64'(sumW[2]), 64'h5A);
        cmp("async_rst_val", 2, 64'(ovW[2]),  64'h0);

        // Random traffic against the model, with one extra reset midway.
        for (int n = 0; n < 600; n++) begin
            randomData();
            if (n == 300) begin
                in_valid = 1'b0;
                midCycleReset("rand_rst");
            end
            applyStimulus("rand",
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 2) != 0),
                          4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d comparisons made", nChecks);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
